cdc_handshake_src: RTL

//  Source (sending) end of a 4-phase req/ack handshake used to move a multi-bit word

---
 rtl/cdc_pkg.sv | 17 +
 rtl/cdc_sync.sv | 28 ++
 rtl/cdc_handshake_src.sv | 101 ++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared types for the req/ack word-crossing blocks.
// Both the source and destination ends use hs_src_state_t.
package cdc_pkg;

    // Handshake source states.
    //   HS_IDLE  : ready for a new word
    //   HS_REQ   : req high, waiting for synchronized ack
    //   HS_REL   : req dropped, waiting for ack to fall
    //   HS_DRAIN : after reset, waiting out a stale ack
    typedef enum logic [1:0] {
        HS_IDLE  = 2'd0,
        HS_REQ   = 2'd1,
        HS_REL   = 2'd2,
        HS_DRAIN = 2'd3
    } hs_src_state_t;

endpackage

// File: rtl/cdc_sync.sv
// Two-flop synchronizer for level signals entering the clk domain.
// Ports: clk, clr (sync clear to INIT_VALUE), d (async in), q (synced out).
module cdc_sync #(
    parameter int             WID        = 1,
    parameter logic [WID-1:0] INIT_VALUE = '0
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [WID-1:0] d,
    output logic [WID-1:0] q
);

    logic [WID-1:0] meta;
    logic [WID-1:0] sync;

    always_ff @(posedge clk) begin
        if (clr) begin
            meta <= INIT_VALUE;
            sync <= INIT_VALUE;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/cdc_handshake_src.sv
// Source end of a 4-phase req/ack word crossing.
// Ports: clk, rst_n (sync, active low), data_in/valid_in/ready_out
// (accept side), done_out (ack pulse), req_out/data_out/ack_in (crossing).
module cdc_handshake_src
    import cdc_pkg::*;
#(
    parameter int             WID        = 8,
    parameter logic [WID-1:0] INIT_VALUE = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [WID-1:0] data_in,
    input  logic           valid_in,
    output logic           ready_out,
    output logic           done_out,
    output logic           req_out,
    output logic [WID-1:0] data_out,
    input  logic           ack_in
);

    hs_src_state_t  state;
    hs_src_state_t  state_nx;
    logic           ack_s;
    logic           accept;
    logic           req_nx;
    logic           done_nx;
    logic [WID-1:0] data_nx;

    // The ack synchronizer is never cleared by rst_n: it must keep
    // showing an ack the destination still holds from a transfer
    // that reset cut off, so DRAIN can wait for it to fall.
    cdc_sync #(
        .WID        (1),
        .INIT_VALUE (1'b0)
    ) u_ack_sync (
        .clk (clk),
        .clr (1'b0),
        .d   (ack_in),
        .q   (ack_s)
    );

    assign ready_out = rst_n && (state == HS_IDLE);
    assign accept    = valid_in && ready_out;

    always_comb begin
        state_nx = state;
        req_nx   = req_out;
        done_nx  = 1'b0;
        data_nx  = data_out;
        case (state)
            HS_IDLE: begin
                // A stray ack_s here is ignored.
                req_nx = 1'b0;
                if (accept) begin
                    data_nx  = data_in;
                    req_nx   = 1'b1;
                    state_nx = HS_REQ;
                end
            end
            HS_REQ: begin
                req_nx = 1'b1;
                if (ack_s) begin
                    req_nx   = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = HS_REL;
                end
            end
            HS_REL: begin
                req_nx = 1'b0;
                if (!ack_s) begin
                    state_nx = HS_IDLE;
                end
            end
            HS_DRAIN: begin
                req_nx = 1'b0;
                if (!ack_s) begin
                    state_nx = HS_IDLE;
                end
            end
            default: begin
                req_nx   = 1'b0;
                state_nx = HS_DRAIN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= HS_DRAIN;
            req_out  <= 1'b0;
            done_out <= 1'b0;
            data_out <= INIT_VALUE;
        end else begin
            state    <= state_nx;
            req_out  <= req_nx;
            done_out <= done_nx;
            data_out <= data_nx;
        end
    end

endmodule
